// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the external-RAM controller state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ram_state_e;

endpackage

// File: rtl/ram1r1w_be.sv
// Synchronous 1-read/1-write RAM with per-byte write enables and a registered read port.
module ram1r1w_be #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wbe,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // A read and a write to the same word in one cycle return the old contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_ext_ram.sv
// AHB-Lite subordinate fronting an on-chip RAM: configurable wait states,
// two-cycle ERROR for out-of-range accesses, write-to-read forwarding.
module ahb_ext_ram #(
  parameter int                 PA_BITS         = 32,
  parameter int                 AHBW            = 64,
  parameter logic [PA_BITS-1:0] BASE            = 32'h8000_0000,
  parameter int                 ADDR_WORDS_LOG2 = 12,
  parameter int                 WAIT_STATES     = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic                 HWRITE,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic                 HREADY,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  output logic [AHBW-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  import ahb_pkg::*;

  localparam int BYTES     = AHBW / 8;
  localparam int BYTE_LOG2 = $clog2(BYTES);
  localparam int IDX_W     = ADDR_WORDS_LOG2;
  localparam int OFF_W     = IDX_W + BYTE_LOG2;
  localparam logic [PA_BITS:0] RANGE_BYTES = {{PA_BITS{1'b0}}, 1'b1} << OFF_W;

  ram_state_e            r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [2:0]            r_wait_cnt;
  logic                  r_wr_pend;
  logic                  r_rd_pend;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_fwd;
  logic [AHBW-1:0]       r_fwd_data;
  logic [BYTES-1:0]      r_fwd_strb;

  logic [PA_BITS-1:0]    w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_commit;
  logic                  w_fwd_hit;
  logic [AHBW-1:0]       w_ram_rdata;
  logic [AHBW-1:0]       w_merged;
  logic                  w_unused;

  assign w_unused = ^{HSIZE, HBURST, HPROT, HMASTLOCK};

  // Offset wraps for addresses below BASE, so one unsigned compare rejects both sides.
  assign w_off       = HADDR - BASE;
  assign w_in_range  = {1'b0, w_off} < RANGE_BYTES;
  assign w_idx       = w_off[OFF_W-1:BYTE_LOG2];
  assign w_accept    = HSEL && HREADY && r_hreadyout &&
                       (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign w_rd_accept = w_accept && w_in_range && !HWRITE;
  assign w_commit    = r_wr_pend && r_hreadyout;
  assign w_fwd_hit   = w_rd_accept && w_commit && (w_idx == r_idx);

  ram1r1w_be #(
    .DATA_W (AHBW),
    .ADDR_W (IDX_W)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_commit),
    .i_waddr (r_idx),
    .i_wdata (HWDATA),
    .i_wbe   (HWSTRB),
    .i_re    (w_rd_accept),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );

  // ERR2 already shows HREADYOUT=1, so it accepts the next address phase like IDLE.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          if (w_accept) begin
            if (!w_in_range) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              r_state     <= ST_WAIT;
              r_hreadyout <= 1'b0;
              r_wait_cnt  <= 3'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          r_wait_cnt  <= '0;
        end
      endcase
    end
  end

  // Data-phase bookkeeping only advances when the current data phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_pend  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_idx      <= '0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_strb <= '0;
    end else if (r_hreadyout) begin
      r_wr_pend  <= w_accept && w_in_range && HWRITE;
      r_rd_pend  <= w_rd_accept;
      if (w_accept) r_idx <= w_idx;
      r_fwd      <= w_fwd_hit;
      r_fwd_data <= HWDATA;
      r_fwd_strb <= HWSTRB;
    end
  end

  always_comb begin
    w_merged = w_ram_rdata;
    for (int b = 0; b < BYTES; b++) begin
      if (r_fwd && r_fwd_strb[b]) w_merged[b*8 +: 8] = r_fwd_data[b*8 +: 8];
    end
  end

  assign HRDATA    = r_rd_pend ? w_merged : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_ext_ram.sv
// Scoreboard bench for ahb_ext_ram: a zero-wait and a three-wait instance share one
// AHB-Lite bus behind a small data-phase mux.
module tb_ahb_ext_ram;

  import ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'd32768;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          waits;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } exp_t;

  logic        HCLK, HRESETn, hsel0, hsel3, HWRITE, dpSel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [63:0] HWDATA;
  logic [7:0]  HWSTRB;
  logic [63:0] rd0, rd3, busRdata;
  logic        ro0, ro3, rsp0, rsp3, busReady, busResp;

  exp_t        sb[$];
  string       tagQ[$];
  logic [63:0] model [int];
  int          checks = 0;
  int          errors = 0;

  ahb_ext_ram #(.PA_BITS(32), .AHBW(64), .BASE(BASE), .ADDR_WORDS_LOG2(12), .WAIT_STATES(0)) u_ram0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(3'b011), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HREADY(busReady), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rsp0));

  ahb_ext_ram #(.PA_BITS(32), .AHBW(64), .BASE(BASE), .ADDR_WORDS_LOG2(12), .WAIT_STATES(3)) u_ram3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(3'b011), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HREADY(busReady), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rsp3));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Interconnect data-phase select follows the address phase that the bus accepted.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dpSel <= 1'b0;
    else if (busReady) dpSel <= hsel3;
  end

  assign busReady = dpSel ? ro3  : ro0;
  assign busResp  = dpSel ? rsp3 : rsp0;
  assign busRdata = dpSel ? rd3  : rd0;

  function automatic int key(input int dut, input logic [31:0] addr);
    return dut * 65536 + int'((addr - BASE) >> 3);
  endfunction

  function automatic logic [63:0] mergeBytes(input logic [63:0] old, input logic [63:0] nw,
                                             input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called on a negedge: presents a new address phase alongside the previous data phase,
  // retires that data phase against the scoreboard, then queues the new expectation.
  task automatic applyStimulus(input string tag, input int dut, input logic [1:0] trans,
                               input logic wr, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [7:0] strb);
    exp_t  e;
    string t;
    int    waits;
    int    k;
    hsel0  = (dut == 0);
    hsel3  = (dut == 3);
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    if (sb.size() > 0) begin
      HWDATA = sb[0].wdata;
      HWSTRB = sb[0].strb;
    end else begin
      HWDATA = '0;
      HWSTRB = '0;
    end
    waits = 0;
    while (busReady !== 1'b1 && waits < 16) begin
      if (sb.size() > 0) checkOutput({tagQ[0], "/respInWait"}, 64'(busResp), 64'(sb[0].err));
      waits++;
      @(negedge HCLK);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, "/waits"}, 64'(waits), 64'(e.waits));
      checkOutput({t, "/resp"}, 64'(busResp), 64'(e.err));
      checkOutput({t, "/rdata"}, busRdata, e.data);
    end else if (waits >= 16) begin
      checkOutput({tag, "/busTimeout"}, 64'(waits), 64'd0);
    end
    e.data  = '0;
    e.err   = 1'b0;
    e.waits = 0;
    e.wdata = wdata;
    e.strb  = strb;
    if (dut >= 0 && trans[1]) begin
      if ((addr - BASE) >= SPAN) begin
        e.err   = 1'b1;
        e.waits = 1;
      end else begin
        k = key(dut, addr);
        e.waits = (dut == 3) ? 3 : 0;
        if (wr) model[k] = mergeBytes(model.exists(k) ? model[k] : 64'hx, wdata, strb);
        else e.data = model.exists(k) ? model[k] : 64'hx;
      end
    end
    sb.push_back(e);
    tagQ.push_back(tag);
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    hsel0 = 1'b0; hsel3 = 1'b0;
    HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0; HWDATA = '0; HWSTRB = '0;
    repeat (3) @(negedge HCLK);
    checkOutput("reset/ready0", 64'(ro0), 64'd1);
    checkOutput("reset/resp0", 64'(rsp0), 64'd0);
    checkOutput("reset/rdata0", rd0, 64'd0);
    checkOutput("reset/ready3", 64'(ro3), 64'd1);
    checkOutput("reset/resp3", 64'(rsp3), 64'd0);
    checkOutput("reset/rdata3", rd3, 64'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    applyStimulus("w0_word0", 0, HTRANS_NONSEQ, 1'b1, BASE, 64'h0123456789ABCDEF, 8'hFF);
    applyStimulus("w0_base8", 0, HTRANS_NONSEQ, 1'b1, BASE + 8, 64'h1122334455667788, 8'hFF);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);
    applyStimulus("r0_base8", 0, HTRANS_NONSEQ, 1'b0, BASE + 8, '0, '0);
    applyStimulus("w0_base16_zero", 0, HTRANS_NONSEQ, 1'b1, BASE + 16, 64'h0, 8'hFF);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);
    applyStimulus("w0_base16_part", 0, HTRANS_NONSEQ, 1'b1, BASE + 16, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    applyStimulus("r0_base16_fwd", 0, HTRANS_SEQ, 1'b0, BASE + 16, '0, '0);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);
    applyStimulus("r0_base16_ram", 0, HTRANS_NONSEQ, 1'b0, BASE + 16, '0, '0);
    applyStimulus("busy0", 0, HTRANS_BUSY, 1'b1, BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyStimulus("r0_base8_afterBusy", 0, HTRANS_NONSEQ, 1'b0, BASE + 8, '0, '0);
    applyStimulus("w0_outOfRange", 0, HTRANS_NONSEQ, 1'b1, BASE + SPAN, 64'hDEADBEEF_DEADBEEF, 8'hFF);
    applyStimulus("r0_belowBase", 0, HTRANS_NONSEQ, 1'b0, BASE - 8, '0, '0);
    applyStimulus("r0_word0", 0, HTRANS_NONSEQ, 1'b0, BASE, '0, '0);

    applyStimulus("w3_word0", 3, HTRANS_NONSEQ, 1'b1, BASE, 64'h5555666677778888, 8'hFF);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);
    applyStimulus("r3_word0", 3, HTRANS_NONSEQ, 1'b0, BASE, '0, '0);
    applyStimulus("w3_outOfRange", 3, HTRANS_NONSEQ, 1'b1, BASE + SPAN, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyStimulus("r3_word0_afterErr", 3, HTRANS_NONSEQ, 1'b0, BASE, '0, '0);
    applyStimulus("w3_base24", 3, HTRANS_NONSEQ, 1'b1, BASE + 24, 64'h0102030405060708, 8'hFF);
    applyStimulus("w3_base24_part", 3, HTRANS_NONSEQ, 1'b1, BASE + 24, 64'hCAFEF00D_99999999, 8'hF0);
    applyStimulus("r3_base24_fwd", 3, HTRANS_NONSEQ, 1'b0, BASE + 24, '0, '0);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);
    applyStimulus("r3_base24_ram", 3, HTRANS_NONSEQ, 1'b0, BASE + 24, '0, '0);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);

    // Reset arrives while a write to word 0 of the wait-state instance is stalled.
    hsel3 = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = BASE; HWDATA = '0; HWSTRB = '0;
    @(negedge HCLK);
    hsel3 = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HWDATA = 64'hBAD0BAD0_BAD0BAD0; HWSTRB = 8'hFF;
    checkOutput("rstMid/stalled", 64'(ro3), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    checkOutput("rstMid/ready", 64'(ro3), 64'd1);
    checkOutput("rstMid/resp", 64'(rsp3), 64'd0);
    checkOutput("rstMid/rdata", rd3, 64'd0);
    sb.delete();
    tagQ.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    applyStimulus("r3_word0_afterReset", 3, HTRANS_NONSEQ, 1'b0, BASE, '0, '0);
    applyStimulus("idle", -1, HTRANS_IDLE, 1'b0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
